// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, owner codes and the
// default SRAM geometry also used by the CTL and DMA blocks.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_DATA_W = 32;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACC_CPU = 2'd1;
    localparam logic [1:0] ACC_DMA = 2'd2;

    typedef logic owner_t;
    localparam owner_t OWN_CPU = 1'b0;
    localparam owner_t OWN_DMA = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection for the SRAM arbiter. Fixed CPU priority with a DMA
// starvation override by default; round-robin when SRAM_ARB_RR_EN is defined.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic [7:0] starve_cnt,
    input  owner_t     rr_last,
    output owner_t     owner,
    output logic       valid
);

    logic conflict;
    assign conflict = cpu_req && dma_req;
    assign valid    = cpu_req || dma_req;

`ifdef SRAM_ARB_RR_EN
    // The starvation counter is tied off in this build.
    logic unused_starve;
    assign unused_starve = ^starve_cnt;

    always_comb begin
        owner = dma_req ? OWN_DMA : OWN_CPU;
        if (conflict)
            owner = (rr_last == OWN_DMA) ? OWN_CPU : OWN_DMA;
    end
`else
    logic unused_rr;
    assign unused_rr = rr_last;

    always_comb begin
        owner = dma_req ? OWN_DMA : OWN_CPU;
        if (conflict)
            owner = (starve_cnt == 8'(STARVE_LIMIT)) ? OWN_DMA : OWN_CPU;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (CPU, DMA) arbiter for the single-port SRAM with registered
// commands and 2-cycle read latency. Define SRAM_ARB_RR_EN for round-robin.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              sram_EN,
    output logic              sram_WE,
    output logic [ADDR_W-1:0] sram_ADDR,
    output logic [DATA_W-1:0] sram_DI,
    input  logic [DATA_W-1:0] sram_DO
);

    logic [1:0]        state;
    logic [7:0]        starve_cnt;
    owner_t            rr_last;
    owner_t            owner;
    logic              pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    sram_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .starve_cnt(starve_cnt),
        .rr_last   (rr_last),
        .owner     (owner),
        .valid     (pick_valid)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (owner == OWN_DMA) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

    assign cpu_rdata = sram_DO;
    assign dma_rdata = sram_DO;

    // Every access is IDLE -> ACC_x -> IDLE; requests are only looked at in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sram_EN    <= 1'b0;
            sram_WE    <= 1'b0;
            sram_ADDR  <= '0;
            sram_DI    <= '0;
            cpu_gnt    <= 1'b0;
            dma_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            rr_last    <= OWN_DMA;
        end else begin
            case (state)
                IDLE: begin
                    cpu_rvalid <= 1'b0;
                    dma_rvalid <= 1'b0;
                    if (pick_valid) begin
                        state     <= (owner == OWN_DMA) ? ACC_DMA : ACC_CPU;
                        sram_EN   <= 1'b1;
                        sram_WE   <= sel_we;
                        sram_ADDR <= sel_addr;
                        if (sel_we)
                            sram_DI <= sel_wdata;
                        cpu_gnt   <= (owner == OWN_CPU);
                        dma_gnt   <= (owner == OWN_DMA);
                        rr_last   <= owner;
                    end else begin
                        sram_EN <= 1'b0;
                        sram_WE <= 1'b0;
                        cpu_gnt <= 1'b0;
                        dma_gnt <= 1'b0;
                    end
                end
                ACC_CPU, ACC_DMA: begin
                    state      <= IDLE;
                    sram_EN    <= 1'b0;
                    sram_WE    <= 1'b0;
                    cpu_gnt    <= 1'b0;
                    dma_gnt    <= 1'b0;
                    cpu_rvalid <= (state == ACC_CPU) && !sram_WE;
                    dma_rvalid <= (state == ACC_DMA) && !sram_WE;
                end
                default: begin
                    state   <= IDLE;
                    sram_EN <= 1'b0;
                    sram_WE <= 1'b0;
                    cpu_gnt <= 1'b0;
                    dma_gnt <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_RR_EN
    assign starve_cnt = '0;
`else
    // Counts IDLE cycles in which the DMA asked and lost; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE && pick_valid) begin
            if (owner == OWN_DMA)
                starve_cnt <= '0;
            else if (dma_req && starve_cnt != 8'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a vector table for single accesses plus
// hand-written sequences for contention, reset mid-access and late requests.
module tb_sram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          sram_EN, sram_WE;
    logic [AW-1:0] sram_ADDR;
    logic [DW-1:0] sram_DI;
    logic [DW-1:0] sram_DO;

    logic [DW-1:0] mem [0:255];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .sram_EN(sram_EN), .sram_WE(sram_WE), .sram_ADDR(sram_ADDR),
        .sram_DI(sram_DI), .sram_DO(sram_DO)
    );

    // Synchronous single-port SRAM model: DO valid the cycle after EN.
    always @(posedge clk) begin
        if (sram_EN) begin
            if (sram_WE)
                mem[sram_ADDR[7:0]] <= sram_DI;
            else
                sram_DO <= mem[sram_ADDR[7:0]];
        end
    end

    typedef struct {
        logic          creq, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          dreq, dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        logic          e_cg, e_dg, e_cv, e_dv, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_di;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                                input logic [DW-1:0] cwd, input logic dreq, input logic dwe,
                                input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                                input logic [5:0] e_flags, input logic [AW-1:0] e_addr,
                                input logic [DW-1:0] e_di, input logic [DW-1:0] e_rdata);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        {v.e_cg, v.e_dg, v.e_cv, v.e_dv, v.e_en, v.e_we} = e_flags;
        v.e_addr = e_addr; v.e_di = e_di; v.e_rdata = e_rdata;
        return v;
    endfunction

    initial begin
        logic exp_dma;
        int   k;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;
        sram_DO = '0;

        // flags: {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, sram_EN, sram_WE}
        vt[0] = mk(1, 0, 16'h0010, 0, 0, 0, 0, 0,            6'b100010, 16'h0010, 0,            0);
        vt[1] = mk(0, 0, 0, 0, 0, 0, 0, 0,                   6'b001000, 16'h0010, 0,            32'hDEADBEEF);
        vt[2] = mk(0, 0, 0, 0, 1, 1, 16'h0020, 32'h12345678, 6'b010011, 16'h0020, 32'h12345678, 0);
        vt[3] = mk(0, 0, 0, 0, 0, 0, 0, 0,                   6'b000000, 16'h0020, 32'h12345678, 0);
        vt[4] = mk(1, 0, 16'h0020, 32'hFFFFFFFF, 0, 0, 0, 0, 6'b100010, 16'h0020, 32'h12345678, 0);
        vt[5] = mk(0, 0, 0, 0, 0, 0, 0, 0,                   6'b001000, 16'h0020, 32'h12345678, 32'h12345678);
        vt[6] = mk(0, 0, 0, 0, 0, 0, 0, 0,                   6'b000000, 16'h0020, 32'h12345678, 0);

        do_reset();
        check("rst sram_EN", sram_EN, 0);
        check("rst sram_WE", sram_WE, 0);
        check("rst sram_ADDR", sram_ADDR, 0);
        check("rst sram_DI", sram_DI, 0);
        check("rst gnt", {cpu_gnt, dma_gnt}, 0);
        check("rst rvalid", {cpu_rvalid, dma_rvalid}, 0);

        for (int i = 0; i < 7; i++) begin
            cpu_req = vt[i].creq; cpu_we = vt[i].cwe; cpu_addr = vt[i].caddr; cpu_wdata = vt[i].cwd;
            dma_req = vt[i].dreq; dma_we = vt[i].dwe; dma_addr = vt[i].daddr; dma_wdata = vt[i].dwd;
            step();
            check($sformatf("v%0d cpu_gnt", i), cpu_gnt, vt[i].e_cg);
            check($sformatf("v%0d dma_gnt", i), dma_gnt, vt[i].e_dg);
            check($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, vt[i].e_cv);
            check($sformatf("v%0d dma_rvalid", i), dma_rvalid, vt[i].e_dv);
            check($sformatf("v%0d sram_EN", i), sram_EN, vt[i].e_en);
            check($sformatf("v%0d sram_WE", i), sram_WE, vt[i].e_we);
            check($sformatf("v%0d sram_ADDR", i), sram_ADDR, vt[i].e_addr);
            check($sformatf("v%0d sram_DI", i), sram_DI, vt[i].e_di);
            if (vt[i].e_cv) check($sformatf("v%0d cpu_rdata", i), cpu_rdata, vt[i].e_rdata);
            if (vt[i].e_dv) check($sformatf("v%0d dma_rdata", i), dma_rdata, vt[i].e_rdata);
        end

        // Both masters requesting reads continuously from a fresh reset.
        do_reset();
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        dma_req = 1'b1; dma_addr = 16'h0020;
        exp_dma = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e % 2 == 1) begin
                k = (e - 1) / 2;
`ifdef SRAM_ARB_RR_EN
                exp_dma = (k % 2 == 1);
`else
                exp_dma = (k % 4 == 3);
`endif
                check($sformatf("arb e%0d cpu_gnt", e), cpu_gnt, !exp_dma);
                check($sformatf("arb e%0d dma_gnt", e), dma_gnt, exp_dma);
                check($sformatf("arb e%0d sram_ADDR", e), sram_ADDR, exp_dma ? 16'h0020 : 16'h0010);
            end else begin
                check($sformatf("arb e%0d no gnt", e), {cpu_gnt, dma_gnt, sram_EN}, 0);
                check($sformatf("arb e%0d rvalid", e), {cpu_rvalid, dma_rvalid}, {!exp_dma, exp_dma});
                check($sformatf("arb e%0d rdata", e), exp_dma ? dma_rdata : cpu_rdata,
                      exp_dma ? 32'h12345678 : 32'hDEADBEEF);
            end
        end

        // Reset while a CPU read is in flight: no rvalid, then a clean retry.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        step();
        check("rstacc cpu_gnt", cpu_gnt, 1);
        cpu_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstacc sram_EN", sram_EN, 0);
        check("rstacc gnt", {cpu_gnt, dma_gnt}, 0);
        check("rstacc cpu_rvalid", cpu_rvalid, 0);
        check("rstacc sram_ADDR", sram_ADDR, 0);
        step();
        check("rstacc late rvalid", {cpu_rvalid, dma_rvalid}, 0);
        cpu_req = 1'b1; cpu_addr = 16'h0020;
        step();
        check("retry cpu_gnt", cpu_gnt, 1);
        cpu_req = 1'b0;
        step();
        check("retry cpu_rvalid", cpu_rvalid, 1);
        check("retry cpu_rdata", cpu_rdata, 32'h12345678);

        // CPU request rising while the DMA holds the port.
        step();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0030; dma_wdata = 32'hA5A5A5A5;
        step();
        check("late dma_gnt", dma_gnt, 1);
        check("late sram_WE", sram_WE, 1);
        dma_req = 1'b0; dma_we = 1'b0;
        cpu_req = 1'b1; cpu_addr = 16'h0030;
        step();
        check("late acc gnt", {cpu_gnt, dma_gnt}, 0);
        check("late dma_rvalid", dma_rvalid, 0);
        step();
        check("late cpu_gnt", {cpu_gnt, dma_gnt}, 2'b10);
        check("late sram_ADDR", sram_ADDR, 16'h0030);
        cpu_req = 1'b0;
        step();
        check("late cpu_rvalid", cpu_rvalid, 1);
        check("late cpu_rdata", cpu_rdata, 32'hA5A5A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter that shares the single-port SRAM between the CPU controller (instruction fetch, LD/ST) and the DMA engine. It sits between both masters and the SRAM EN/WE/ADDR/DI/DO port and registers every SRAM command. It grants one access at a time and returns read data with a fixed latency. Fixed CPU priority with a DMA anti-starvation counter is the default; round-robin is a build option.

## Interface
- ADDR_W, 16, SRAM word-address width
- DATA_W, 32, SRAM data width
- STARVE_LIMIT, 8, consecutive cycles a DMA request may lose before it is force-granted; legal range 1..255
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request; level, held with cmd fields until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  one-cycle pulse: command is on the SRAM port this cycle
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DATA_W  read data, equal to sram_DO
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as the cpu_* ports, for the DMA
- sram_EN  out  1  SRAM enable, registered
- sram_WE  out  1  SRAM write enable, registered
- sram_ADDR  out  ADDR_W  registered address
- sram_DI  out  DATA_W  registered write data
- sram_DO  in  DATA_W  SRAM read data, valid the cycle after EN

## Operation
- States: IDLE, ACC_CPU, ACC_DMA.
- IDLE, no request: all SRAM outputs and pulses are 0 next cycle; stay in IDLE.
- IDLE, request present: pick a winner. On the next edge:
  - load sram_EN=1, sram_WE=we, sram_ADDR=addr and sram_DI=wdata (wdata for writes only; sram_DI holds its value on reads);
  - assert the winner's gnt;
  - go to ACC_<winner>.
- ACC_x: always return to IDLE on the next edge. That edge clears sram_EN, sram_WE and gnt_x, and sets rvalid_x to 1 if the access was a read.
- ACC_x ignores all requests. The next arbitration happens in the following IDLE cycle, concurrent with rvalid.
- A requester must deassert req or present a new command during the cycle cpu_gnt/dma_gnt is high. A req still high in the following IDLE cycle is a new access.
- Winner selection with both requesting:
  - default: CPU wins, unless starve_cnt == STARVE_LIMIT, then DMA wins.
  - starve_cnt increments each IDLE cycle in which the DMA requests and loses.
  - starve_cnt clears on any dma_gnt.
  - starve_cnt saturates at STARVE_LIMIT.
- Only one requester active: that requester wins regardless of mode.
- sram_ADDR and sram_DI hold their last values when idle. The rdata outputs are combinational copies of sram_DO.

## Timing
- Reset values: sram_EN=0, sram_WE=0, sram_ADDR=0, sram_DI=0, all gnt=0, all rvalid=0, state IDLE, starve_cnt=0, rr_last=DMA.
- Read: req sampled in cycle 0 → gnt and sram_EN high in cycle 1 → rvalid in cycle 2 with rdata = mem[addr]. Latency is 2 cycles.
- Write: gnt and sram_EN/WE high in cycle 1; memory is updated at the end of cycle 1; no rvalid.
- Peak throughput is one access per 2 cycles. Back-to-back grants are possible in cycles 1, 3, 5, …
- gnt and rvalid are never high for both requesters in the same cycle.
- Reset asserted in ACC_x: the next edge applies reset values. The in-flight access produces no rvalid, and the SRAM write of that cycle still occurs.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin mode.
  - On a conflict, the requester other than rr_last wins; rr_last updates on every grant.
  - starve_cnt and the STARVE_LIMIT logic are compiled out.
- SRAM_ARB_RR_EN undefined: fixed CPU priority with starvation override, as described under Operation.

## Structure
- Shared package sram_arb_pkg: state encoding (IDLE, ACC_CPU, ACC_DMA), owner encoding (OWN_CPU=0, OWN_DMA=1), and the default ADDR_W/DATA_W constants shared with the CTL and DMA blocks.
- One sub-module, sram_arb_pick.
  - Inputs: both reqs, starve_cnt, rr_last.
  - Output: the winner owner and a valid flag.
  - Holds all mode-dependent selection, so the FSM and SRAM register logic are identical in both builds.

## Test plan
- CPU-only read: cpu_req, addr 0x0010 with mem=0xDEADBEEF at cycle 0 → cpu_gnt cycle 1, sram_EN=1 ADDR=0x0010 cycle 1, cpu_rvalid and rdata=0xDEADBEEF cycle 2; dma_* stay 0.
- DMA write then CPU read of the same address: DMA writes 0x12345678 to 0x0020, then the CPU reads 0x0020 → cpu_rdata=0x12345678; sram_WE high only during the DMA grant cycle.
- Both requesting continuously, fixed mode, STARVE_LIMIT=3 → grants CPU,CPU,CPU,DMA repeating; starve_cnt resets after each dma_gnt.
- Both requesting continuously, SRAM_ARB_RR_EN defined → grants alternate CPU,DMA,CPU,DMA starting with CPU after reset.
- Reset asserted in ACC_CPU during a read → next cycle sram_EN=0, no cpu_rvalid, state IDLE; a fresh request afterwards completes with 2-cycle latency.
- Request arriving during ACC_DMA: cpu_req rises in the dma_gnt cycle → cpu_gnt two cycles later, never overlapping dma_gnt.
